// File: rtl/stall_ctrl_if.sv
// Hazard-control bundle between the RV32 pipeline and stall_ctrl.
// The master is the pipeline, which drives the hazard inputs and receives the stall/flush enables.
interface stall_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             PCsrcE;
   logic             LoadE;
   logic [4:0]       rdE;
   logic [4:0]       rs1D;
   logic [4:0]       rs2D;
   logic             MdStartE;
   logic             MdDoneE;
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             FlushD;
   logic             FlushE;
   logic             FlushM;
   logic             md_timeout;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output PCsrcE, LoadE, rdE, rs1D, rs2D, MdStartE, MdDoneE,
      input  StallF, StallD, StallE, FlushD, FlushE, FlushM, md_timeout, stall_cycles
   );

   modport slave (
      input  PCsrcE, LoadE, rdE, rs1D, rs2D, MdStartE, MdDoneE,
      output StallF, StallD, StallE, FlushD, FlushE, FlushM, md_timeout, stall_cycles
   );
endinterface

// File: rtl/stall_ctrl.sv
// Load-use bubble, mul/div occupancy stall with watchdog, and branch flush for the 5-stage core.
// Stall/flush enables are combinational from hazard inputs plus the RUN/MDU_BUSY state.
module stall_ctrl #(
   parameter int MDU_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic         clk,
   input  logic         rst,
   stall_ctrl_if.slave  ctl
);
   localparam int BW = $clog2(MDU_TIMEOUT + 1);
   localparam logic [BW-1:0] TMO = BW'(MDU_TIMEOUT);

   typedef enum logic {RUN, MDU_BUSY} state_t;

   state_t           state;
   logic [BW-1:0]    busy_cnt;
   logic             md_timeout;
   logic [CNT_W-1:0] stall_cycles;

   logic lw_stall;
   logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;

   assign lw_stall = ctl.LoadE && (ctl.rdE != 5'd0) &&
                     ((ctl.rdE == ctl.rs1D) || (ctl.rdE == ctl.rs2D));

   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      if (!rst) begin
         case (state)
            RUN: begin
               if (ctl.PCsrcE) begin
                  flush_d = 1'b1;
                  flush_e = 1'b1;
               end else if (ctl.MdStartE) begin
                  // A same-cycle done means the result is ready; no occupancy to cover.
                  if (!ctl.MdDoneE) begin
                     stall_f = 1'b1;
                     stall_d = 1'b1;
                     stall_e = 1'b1;
                     flush_m = 1'b1;
                  end
               end else if (lw_stall) begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  flush_e = 1'b1;
               end
            end
            MDU_BUSY: begin
               if (!ctl.MdDoneE && (busy_cnt < TMO)) begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  stall_e = 1'b1;
                  flush_m = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= RUN;
         busy_cnt     <= '0;
         md_timeout   <= 1'b0;
         stall_cycles <= '0;
      end else begin
         case (state)
            RUN: begin
               if (!ctl.PCsrcE && ctl.MdStartE && !ctl.MdDoneE) begin
                  state    <= MDU_BUSY;
                  busy_cnt <= BW'(1);
               end
            end
            MDU_BUSY: begin
               if (ctl.MdDoneE) begin
                  state    <= RUN;
                  busy_cnt <= '0;
               end else if (busy_cnt < TMO) begin
                  busy_cnt <= busy_cnt + 1'b1;
               end else begin
                  // Watchdog expiry: release the pipeline and flag it until reset.
                  md_timeout <= 1'b1;
                  state      <= RUN;
                  busy_cnt   <= '0;
               end
            end
            default: state <= RUN;
         endcase
         if (stall_f && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
      end
   end

   assign ctl.StallF       = stall_f;
   assign ctl.StallD       = stall_d;
   assign ctl.StallE       = stall_e;
   assign ctl.FlushD       = flush_d;
   assign ctl.FlushE       = flush_e;
   assign ctl.FlushM       = flush_m;
   assign ctl.md_timeout   = md_timeout;
   assign ctl.stall_cycles = stall_cycles;
endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: single-cycle hazard vectors from a table, then multi-cycle MDU, timeout, saturation and async-reset sequences.
module tb_stall_ctrl;
   localparam int CNT_W = 3;
   localparam int TMO   = 8;

   // Output vector order: {StallF, StallD, StallE, FlushD, FlushE, FlushM}
   localparam logic [5:0] O_NONE = 6'b000000;
   localparam logic [5:0] O_LW   = 6'b110010;
   localparam logic [5:0] O_MDU  = 6'b111001;
   localparam logic [5:0] O_BR   = 6'b000110;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   stall_ctrl_if #(.CNT_W(CNT_W)) ifc ();

   stall_ctrl #(.MDU_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .ctl (ifc.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       pc;
      logic       ld;
      logic [4:0] rd;
      logic [4:0] r1;
      logic [4:0] r2;
      logic       st;
      logic       dn;
      logic [5:0] exp_o;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [5:0] outs();
      return {ifc.StallF, ifc.StallD, ifc.StallE, ifc.FlushD, ifc.FlushE, ifc.FlushM};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic pc, input logic ld, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic st, input logic dn);
      ifc.PCsrcE   = pc;
      ifc.LoadE    = ld;
      ifc.rdE      = rd;
      ifc.rs1D     = r1;
      ifc.rs2D     = r2;
      ifc.MdStartE = st;
      ifc.MdDoneE  = dn;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{"idle",          0, 0,  0,  0,  0, 0, 0, O_NONE};
      vecs[1]  = '{"lw_rs2",        0, 1,  5,  1,  5, 0, 0, O_LW};
      vecs[2]  = '{"lw_rs1",        0, 1,  5,  5,  1, 0, 0, O_LW};
      vecs[3]  = '{"lw_nomatch",    0, 1,  5,  4,  6, 0, 0, O_NONE};
      vecs[4]  = '{"noload_match",  0, 0,  5,  5,  5, 0, 0, O_NONE};
      vecs[5]  = '{"lw_x0",         0, 1,  0,  0,  0, 0, 0, O_NONE};
      vecs[6]  = '{"br_over_lw",    1, 1,  7,  7,  0, 0, 0, O_BR};
      vecs[7]  = '{"br_over_mdu",   1, 0,  0,  0,  0, 1, 0, O_BR};
      vecs[8]  = '{"lw_after_br",   0, 1,  3,  0,  3, 0, 0, O_LW};
      vecs[9]  = '{"mdu_single",    0, 0,  0,  0,  0, 1, 1, O_NONE};
      vecs[10] = '{"mdu1_over_lw",  0, 1,  9,  9,  0, 1, 1, O_NONE};
      vecs[11] = '{"lw_x31_both",   0, 1, 31, 31, 31, 0, 0, O_LW};

      // Reset state, including hazard inputs being ignored while rst is high
      drive(0, 1, 5, 5, 5, 0, 0);
      #2;
      check("rst_outs_gated", outs(), O_NONE);
      check("rst_cnt", ifc.stall_cycles, 0);
      check("rst_tmo", ifc.md_timeout, 0);
      do_reset();

      foreach (vecs[i]) begin
         drive(vecs[i].pc, vecs[i].ld, vecs[i].rd, vecs[i].r1, vecs[i].r2, vecs[i].st, vecs[i].dn);
         #2;
         check(vecs[i].name, outs(), vecs[i].exp_o);
         step();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      check("table_cnt", ifc.stall_cycles, 4);

      // Load-use bubble lasts exactly one cycle
      do_reset();
      drive(0, 1, 5, 0, 5, 0, 0);
      #2;
      check("lu_bubble", outs(), O_LW);
      step();
      drive(0, 0, 5, 0, 5, 0, 0);
      #2;
      check("lu_clear", outs(), O_NONE);
      check("lu_cnt", ifc.stall_cycles, 1);
      step();

      // Multi-cycle MDU: done 4 cycles after start; branch/load-use masked while busy
      do_reset();
      drive(0, 0, 0, 0, 0, 1, 0);
      #2;
      check("mdu_c0", outs(), O_MDU);
      step();
      for (int c = 1; c < 4; c++) begin
         if (c == 2) drive(1, 1, 6, 6, 0, 0, 0);
         else        drive(0, 0, 0, 0, 0, 0, 0);
         #2;
         check($sformatf("mdu_c%0d", c), outs(), O_MDU);
         step();
      end
      drive(0, 0, 0, 0, 0, 0, 1);
      #2;
      check("mdu_done", outs(), O_NONE);
      step();
      drive(0, 1, 2, 2, 0, 0, 0);
      #2;
      check("mdu_cnt", ifc.stall_cycles, 4);
      check("mdu_back_run", outs(), O_LW);
      check("mdu_no_tmo", ifc.md_timeout, 0);
      step();

      // Watchdog: 8 stall cycles, then release, sticky flag, counter saturates at 7
      do_reset();
      drive(0, 0, 0, 0, 0, 1, 0);
      #2;
      check("tmo_c0", outs(), O_MDU);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int c = 1; c < TMO; c++) begin
         #2;
         check($sformatf("tmo_c%0d", c), outs(), O_MDU);
         step();
      end
      #2;
      check("tmo_release", outs(), O_NONE);
      check("tmo_sat", ifc.stall_cycles, 7);
      check("tmo_flag_pre", ifc.md_timeout, 0);
      step();
      drive(0, 1, 4, 0, 4, 0, 0);
      #2;
      check("tmo_flag", ifc.md_timeout, 1);
      check("tmo_lw_after", outs(), O_LW);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      check("sat_hold", ifc.stall_cycles, 7);
      check("tmo_sticky", ifc.md_timeout, 1);
      step();

      // Async reset asserted between edges while in MDU_BUSY
      drive(0, 0, 0, 0, 0, 1, 0);
      #2;
      check("ar_start", outs(), O_MDU);
      step();
      drive(0, 0, 0, 0, 0, 0, 0);
      #2;
      check("ar_busy", outs(), O_MDU);
      #1;
      rst = 1'b1;
      #1;
      check("ar_outs", outs(), O_NONE);
      check("ar_cnt", ifc.stall_cycles, 0);
      check("ar_tmo", ifc.md_timeout, 0);
      step();
      rst = 1'b0;
      #2;
      check("ar_run", outs(), O_NONE);
      check("ar_cnt_hold", ifc.stall_cycles, 0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Pipeline-control companion to the forwarding/flush unit in the 5-stage RV32 core.
- Covers hazards that forwarding cannot resolve:
  - load-use dependencies, via a one-cycle bubble;
  - multi-cycle mul/div occupancy in Execute, via an FSM-held stall with a watchdog timeout;
  - taken-branch flush of Decode/Execute, with priority over both.
- Drives the stall/flush enables of the IF/ID, ID/EX and EX/MEM pipeline registers and keeps a saturating stall-cycle performance counter.

Parameters:
- MDU_TIMEOUT, 64, max cycles in MDU_BUSY before forced abort (must be ≥2).
- CNT_W, 32, width of stall_cycles counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- PCsrcE  input  1  taken branch/jump resolved in Execute
- LoadE  input  1  instruction in Execute is a load (ResultSrcE == memory)
- rdE  input  5  destination register of the Execute instruction
- rs1D  input  5  source register 1 of the Decode instruction
- rs2D  input  5  source register 2 of the Decode instruction
- MdStartE  input  1  mul/div instruction entering Execute this cycle
- MdDoneE  input  1  mul/div unit result valid (one-cycle pulse)
- StallF  output  1  hold PC
- StallD  output  1  hold IF/ID register
- StallE  output  1  hold ID/EX register
- FlushD  output  1  clear IF/ID register
- FlushE  output  1  clear ID/EX register
- FlushM  output  1  clear EX/MEM register (bubble into Memory)
- md_timeout  output  1  sticky error flag: mul/div watchdog expired
- stall_cycles  output  CNT_W  count of cycles with StallF=1, saturating

Behaviour:
- Reset (async, rst=1):
  - state=RUN, busy_cnt=0, md_timeout=0, stall_cycles=0.
  - All stall/flush outputs are 0 while rst is high.
- Stall/flush outputs are combinational from current inputs plus the registered state; no added latency.
- lwStall = LoadE & (rdE != 0) & ((rdE == rs1D) | (rdE == rs2D)).
- FSM states: RUN, MDU_BUSY.
- RUN, evaluated in priority order (highest first):
  1. PCsrcE=1: FlushD=1, FlushE=1, all stalls 0; lwStall and MdStartE are ignored; state stays RUN.
  2. MdStartE=1 & MdDoneE=1 (single-cycle result): no stall; stay RUN.
  3. MdStartE=1 & MdDoneE=0: StallF=StallD=StallE=1, FlushM=1; next state MDU_BUSY, busy_cnt←1.
  4. lwStall=1: StallF=StallD=1, FlushE=1 (one bubble); stay RUN. Re-evaluated the next cycle, when the load is in Memory, so the condition clears naturally.
  5. Otherwise all outputs 0.
- MDU_BUSY:
  - MdDoneE=0 and busy_cnt<MDU_TIMEOUT: StallF=StallD=StallE=1, FlushM=1; busy_cnt increments.
  - MdDoneE=1: all stalls and flushes deasserted in that same cycle (the result is captured by EX/MEM on this edge); next state RUN, busy_cnt←0.
  - busy_cnt==MDU_TIMEOUT with MdDoneE=0: md_timeout←1 (sticky until rst); next state RUN; stalls deasserted in this cycle.
  - lwStall and PCsrcE are masked; Decode is already held and is re-evaluated after return to RUN.
- stall_cycles: increments on each rising edge where StallF=1; holds at all-ones, no wrap.
- Reset asserted mid-MDU_BUSY: immediate return to RUN; stalls drop asynchronously.
- rd=x0 never produces a load-use stall.

Test Plan:
- Load-use: LoadE=1, rdE=5, rs2D=5 for 1 cycle, then LoadE=0 → StallF=StallD=FlushE=1 for exactly 1 cycle; stall_cycles=1.
- x0 and priority:
  - LoadE=1, rdE=0, rs1D=0 → no stall.
  - LoadE=1, rdE=7, rs1D=7, PCsrcE=1 → FlushD=FlushE=1, StallF=0, stall_cycles unchanged.
- MDU: MdStartE pulse, MdDoneE pulsed 4 cycles later → StallF/StallD/StallE/FlushM=1 for 4 cycles, 0 in the done cycle, state RUN after; stall_cycles=4.
- Single-cycle MDU: MdStartE=MdDoneE=1 together → no stall, state stays RUN.
- Timeout: MDU_TIMEOUT=8, MdStartE pulse, MdDoneE held 0 → stalls for 8 cycles, md_timeout=1 and stays 1, FSM back in RUN; a new load-use is then handled normally.
- Async reset: assert rst mid-MDU_BUSY between clock edges → outputs 0 immediately, counters 0, md_timeout cleared; saturation check with CNT_W=3 and a long MDU stall → stall_cycles holds at 7.
